// File: rtl/pipe_pkg.sv
// Constants and types shared by the D/E, E/M and M/W pipeline registers.
package pipe_pkg;

  localparam int          TNEW_W       = 2;
  localparam logic [31:0] NOP_INSTR    = 32'h0;
  localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;

  typedef logic [TNEW_W-1:0] tnew_t;

endpackage

// File: rtl/pipe_field.sv
// One pipeline register field: async active-low reset, bubble clear, load enable.
module pipe_field #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/de_pipe_reg.sv
// D/E pipeline register with M-stage operand forwarding and Tnew tracking.
// Optional DE_BUBBLE_STATS_EN adds bubble/hold edge counters.
module de_pipe_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_VAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] imm_d,
  input  logic [4:0]  a3_d,
  input  logic [1:0]  tnew_d,
  input  logic        fwd_rs_m,
  input  logic        fwd_rt_m,
  input  logic [31:0] fwd_data_m,
  output logic [31:0] instr_e,
  output logic [31:0] pc_e,
  output logic [31:0] rs_val_e,
  output logic [31:0] rt_val_e,
  output logic [31:0] imm_e,
  output logic [4:0]  a3_e,
  output logic [1:0]  tnew_e,
  output logic        valid_e
`ifdef DE_BUBBLE_STATS_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] hold_cnt
`endif
);

  // Writes to $0 never produce a result anyone waits on, so report Tnew 0.
  function automatic tnew_t tnew_next(input logic [4:0] a3, input tnew_t t);
    if (a3 == 5'd0 || t == '0) return '0;
    return t - tnew_t'(1);
  endfunction

  logic [31:0] rs_val_p0;
  logic [31:0] rt_val_p0;
  tnew_t       tnew_p0;

  assign rs_val_p0 = fwd_rs_m ? fwd_data_m : rd1_d;
  assign rt_val_p0 = fwd_rt_m ? fwd_data_m : rd2_d;
  assign tnew_p0   = tnew_next(a3_d, tnew_t'(tnew_d));

  // ---- D/E boundary ----
  pipe_field #(.DATA_W(32), .RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d(instr_d), .q(instr_e));

  pipe_field #(.DATA_W(32), .RST_VAL(PC_RESET)) u_pc (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d(pc_d), .q(pc_e));

  pipe_field #(.DATA_W(32), .RST_VAL(32'h0)) u_rs_val (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d(rs_val_p0), .q(rs_val_e));

  pipe_field #(.DATA_W(32), .RST_VAL(32'h0)) u_rt_val (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d(rt_val_p0), .q(rt_val_e));

  pipe_field #(.DATA_W(32), .RST_VAL(32'h0)) u_imm (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d(imm_d), .q(imm_e));

  pipe_field #(.DATA_W(5), .RST_VAL(5'h0)) u_a3 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d(a3_d), .q(a3_e));

  pipe_field #(.DATA_W(TNEW_W), .RST_VAL('0)) u_tnew (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d(tnew_p0), .q(tnew_e));

  pipe_field #(.DATA_W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .d(1'b1), .q(valid_e));

`ifdef DE_BUBBLE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= 32'h0;
      hold_cnt   <= 32'h0;
    end else begin
      if (clr)         bubble_cnt <= bubble_cnt + 32'd1;
      if (!clr && !en) hold_cnt   <= hold_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_de_pipe_reg.sv
// Scoreboard bench for de_pipe_reg: expected E-stage bundles queued at drive time.
module tb_de_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, clr;
  logic [31:0] instr_d, pc_d, rd1_d, rd2_d, imm_d, fwd_data_m;
  logic [4:0]  a3_d;
  logic [1:0]  tnew_d;
  logic        fwd_rs_m, fwd_rt_m;
  logic [31:0] instr_e, pc_e, rs_val_e, rt_val_e, imm_e;
  logic [4:0]  a3_e;
  logic [1:0]  tnew_e;
  logic        valid_e;
`ifdef DE_BUBBLE_STATS_EN
  logic [31:0] bubble_cnt, hold_cnt;
`endif

  always #5 clk = ~clk;

  de_pipe_reg #(.PC_RESET(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .instr_d(instr_d), .pc_d(pc_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .imm_d(imm_d), .a3_d(a3_d), .tnew_d(tnew_d),
    .fwd_rs_m(fwd_rs_m), .fwd_rt_m(fwd_rt_m), .fwd_data_m(fwd_data_m),
    .instr_e(instr_e), .pc_e(pc_e), .rs_val_e(rs_val_e), .rt_val_e(rt_val_e),
    .imm_e(imm_e), .a3_e(a3_e), .tnew_e(tnew_e), .valid_e(valid_e)
`ifdef DE_BUBBLE_STATS_EN
    , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic        valid;
  } bundle_t;

  bundle_t model;
  bundle_t sb_q[$];
  int      checks = 0;
  int      errors = 0;
  int      exp_bub = 0;
  int      exp_hold = 0;

  localparam bundle_t RESET_B = '{instr: 32'h0, pc: 32'h0000_3000, rs: 32'h0,
                                  rt: 32'h0, imm: 32'h0, a3: 5'h0, tnew: 2'h0,
                                  valid: 1'b0};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    bundle_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_val({tag, "_instr"}, instr_e, e.instr);
    check_val({tag, "_pc"},    pc_e,    e.pc);
    check_val({tag, "_rs"},    rs_val_e, e.rs);
    check_val({tag, "_rt"},    rt_val_e, e.rt);
    check_val({tag, "_imm"},   imm_e,   e.imm);
    check_val({tag, "_a3"},    32'(a3_e),    32'(e.a3));
    check_val({tag, "_tnew"},  32'(tnew_e),  32'(e.tnew));
    check_val({tag, "_valid"}, 32'(valid_e), 32'(e.valid));
  endtask

  // Drive one D-stage bundle, predict E, then compare just after the edge.
  task automatic drive(input string tag, input logic e_in, input logic c_in,
                       input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [4:0] a3,
                       input logic [1:0] tn, input logic fs, input logic ft,
                       input logic [31:0] fd);
    en = e_in; clr = c_in; instr_d = instr; pc_d = pc; rd1_d = r1; rd2_d = r2;
    imm_d = imm; a3_d = a3; tnew_d = tn; fwd_rs_m = fs; fwd_rt_m = ft; fwd_data_m = fd;
    if (c_in) begin
      model = RESET_B;
      exp_bub++;
    end else if (!e_in) begin
      exp_hold++;
    end else begin
      model.instr = instr;
      model.pc    = pc;
      model.rs    = fs ? fd : r1;
      model.rt    = ft ? fd : r2;
      model.imm   = imm;
      model.a3    = a3;
      model.tnew  = (a3 == 5'd0 || tn == 2'd0) ? 2'd0 : tn - 2'd1;
      model.valid = 1'b1;
    end
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic assert_reset_now(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model = RESET_B;
    exp_bub = 0;
    exp_hold = 0;
    sb_q.push_back(model);
    compare_out(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; clr = 1'b0;
    instr_d = 32'h1234_5678; pc_d = 32'h4000; rd1_d = 32'h11; rd2_d = 32'h22;
    imm_d = 32'h33; a3_d = 5'd7; tnew_d = 2'd2;
    fwd_rs_m = 1'b0; fwd_rt_m = 1'b0; fwd_data_m = 32'h0;
    model = RESET_B;

    #12;
    sb_q.push_back(RESET_B);
    compare_out("reset");
    @(negedge clk);
    reset = 1'b1;

    drive("load", 1, 0, 32'h8C22_0004, 32'h3004, 32'd5, 32'd9, 32'd4, 5'd2, 2'd2, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++)
      drive("hold", 0, 0, 32'hFFFF_0000 + i, 32'h5000 + i, 32'd100 + i, 32'd200 + i,
            32'd7, 5'd9, 2'd3, 1, 1, 32'hABCD_0000);
    drive("bubble_over_hold", 0, 1, 32'h0102_0304, 32'h3010, 32'd1, 32'd2, 32'd3, 5'd4, 2'd2, 0, 0, 32'h0);
    drive("fwd_both", 1, 0, 32'h0022_1820, 32'h3014, 32'd1, 32'd2, 32'd0, 5'd3, 2'd1, 1, 1, 32'hDEAD_BEEF);
    drive("fwd_rs", 1, 0, 32'h0022_1820, 32'h3018, 32'd1, 32'd2, 32'd0, 5'd3, 2'd1, 1, 0, 32'hCAFE_F00D);
    drive("fwd_rt", 1, 0, 32'h0022_1820, 32'h301C, 32'd1, 32'd2, 32'd0, 5'd3, 2'd1, 0, 1, 32'h1357_9BDF);
    drive("tnew_sat", 1, 0, 32'h2001_0001, 32'h3020, 32'd8, 32'd9, 32'd1, 5'd5, 2'd0, 0, 0, 32'h0);
    drive("a3_zero", 1, 0, 32'h8C00_0000, 32'h3024, 32'd8, 32'd9, 32'd1, 5'd0, 2'd3, 0, 0, 32'h0);
    drive("tnew_dec", 1, 0, 32'h8C04_0000, 32'h3028, 32'd8, 32'd9, 32'd1, 5'd4, 2'd3, 0, 0, 32'h0);

    for (int i = 0; i < 4; i++)
      drive("clr_run", i[0], 1, 32'hAAAA_0000 + i, 32'h6000, 32'd1, 32'd2, 32'd3, 5'd6, 2'd2, 1, 0, 32'h5);
`ifdef DE_BUBBLE_STATS_EN
    check_val("bubble_cnt_after_clr", bubble_cnt, 32'(exp_bub));
`endif

    for (int i = 0; i < 20; i++)
      drive("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
            $urandom, $urandom, $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

`ifdef DE_BUBBLE_STATS_EN
    check_val("bubble_cnt", bubble_cnt, 32'(exp_bub));
    check_val("hold_cnt", hold_cnt, 32'(exp_hold));
`endif

    drive("pre_rst_load", 1, 0, 32'h1111_2222, 32'h3100, 32'd3, 32'd4, 32'd5, 5'd8, 2'd2, 0, 0, 32'h0);
    drive("pre_rst_hold", 0, 0, 32'h0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 2'd0, 0, 0, 32'h0);
    assert_reset_now("reset_mid_hold");
`ifdef DE_BUBBLE_STATS_EN
    check_val("hold_cnt_reset", hold_cnt, 32'd0);
`endif
    drive("post_rst_load", 1, 0, 32'h3333_4444, 32'h3104, 32'd6, 32'd7, 32'd8, 5'd9, 2'd1, 0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
